// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the decode->execute operand stage: ALU opcodes and
// default datapath/register-address widths.
package alu_operand_stage_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_AND = 3'b111;
endpackage

// File: rtl/alu_operand_stage_operand_bypass.sv
// Resolves one source operand: x0 zeroing, then EX forwarding from the held
// entry, then WB forwarding, then the register-file read.
module operand_bypass
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] addr,
  input  logic              held_valid,
  input  logic [REG_AW-1:0] held_rd,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   rf_data,
  output logic [XLEN-1:0]   value
);
  always_comb begin
    value = rf_data;
    // EX result is younger than WB, so it wins when both name the same register
    if (addr == '0)
      value = '0;
    else if (held_valid && (held_rd == addr))
      value = alu_result;
    else if (wb_valid && (wb_rd == addr))
      value = wb_data;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// Decode->execute pipeline register feeding the combinational ALU; resolves
// operands on entry and holds them stable until the downstream consumes.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        opcode,
  output logic [XLEN-1:0]   left,
  output logic [XLEN-1:0]   right,
  output logic [REG_AW-1:0] rd
);
  logic              valid_reg;
  logic [2:0]        opcode_reg;
  logic [XLEN-1:0]   left_reg;
  logic [XLEN-1:0]   right_reg;
  logic [REG_AW-1:0] rd_reg;

  logic [XLEN-1:0]   rs1_value;
  logic [XLEN-1:0]   rs2_value;
  logic [XLEN-1:0]   right_next;
  logic              transfer;

  // Held rd of a valid entry forwards regardless of out_ready: the ALU result
  // of the held entry is ready combinationally in the same cycle.
  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs1 (
    .addr       (in_rs1_addr),
    .held_valid (valid_reg),
    .held_rd    (rd_reg),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rf_data    (in_rs1_data),
    .value      (rs1_value)
  );

  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_bypass_rs2 (
    .addr       (in_rs2_addr),
    .held_valid (valid_reg),
    .held_rd    (rd_reg),
    .alu_result (alu_result),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rf_data    (in_rs2_data),
    .value      (rs2_value)
  );

  assign in_ready   = !valid_reg || out_ready;
  assign transfer   = in_valid && in_ready;
  assign right_next = in_use_imm ? in_imm : rs2_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      opcode_reg <= ALU_ADD;
      left_reg   <= '0;
      right_reg  <= '0;
      rd_reg     <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (transfer) begin
      valid_reg  <= 1'b1;
      opcode_reg <= in_opcode;
      left_reg   <= rs1_value;
      right_reg  <= right_next;
      rd_reg     <= in_rd_addr;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign opcode    = opcode_reg;
  assign left      = left_reg;
  assign right     = right_reg;
  assign rd        = rd_reg;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: handshake, forwarding priority,
// stall stability, immediate select, flush and reset behaviour.
module tb_alu_operand_stage;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_opcode;
  logic [REG_AW-1:0] in_rs1_addr;
  logic [REG_AW-1:0] in_rs2_addr;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic              in_use_imm;
  logic [REG_AW-1:0] in_rd_addr;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic [XLEN-1:0]   alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        opcode;
  logic [XLEN-1:0]   left;
  logic [XLEN-1:0]   right;
  logic [REG_AW-1:0] rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd_addr(in_rd_addr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .left(left), .right(right), .rd(rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2,
                       input logic ui, input logic [31:0] imm, input logic [4:0] dst);
    in_valid = v; in_opcode = op;
    in_rs1_addr = a1; in_rs1_data = d1;
    in_rs2_addr = a2; in_rs2_data = d2;
    in_use_imm = ui; in_imm = imm; in_rd_addr = dst;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; alu_result = '0;
    drive(1'b0, 3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    vectors++; if (left !== 32'd0) begin miscompares++; $display("FAIL reset_left got=%h exp=0", left); end
    vectors++; if (right !== 32'd0) begin miscompares++; $display("FAIL reset_right got=%h exp=0", right); end
    vectors++; if (opcode !== 3'b000 || rd !== 5'd0) begin miscompares++; $display("FAIL reset_op_rd got=%b/%0d exp=000/0", opcode, rd); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    $display("test_reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 5'd1, 32'd4, 5'd2, 32'd3, 1'b0, 32'd0, 5'd3);
    tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
    vectors++; if (opcode !== 3'b000) begin miscompares++; $display("FAIL add_opcode got=%b exp=000", opcode); end
    vectors++; if (left !== 32'd4) begin miscompares++; $display("FAIL add_left got=%h exp=4", left); end
    vectors++; if (right !== 32'd3) begin miscompares++; $display("FAIL add_right got=%h exp=3", right); end
    vectors++; if (rd !== 5'd3) begin miscompares++; $display("FAIL add_rd got=%0d exp=3", rd); end
    $display("test_add: op=%b left=%h right=%h rd=%0d", opcode, left, right, rd);
  endtask

  task automatic test_back_to_back();
    // EX result 7 must beat both the stale regfile value and a WB to x3
    alu_result = 32'd7;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55;
    drive(1'b1, 3'b100, 5'd3, 32'h99, 5'd2, 32'd3, 1'b0, 32'd0, 5'd4);
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
    tick();
    wb_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got=%0b exp=1", out_valid); end
    vectors++; if (opcode !== 3'b100) begin miscompares++; $display("FAIL b2b_opcode got=%b exp=100", opcode); end
    vectors++; if (left !== 32'd7) begin miscompares++; $display("FAIL b2b_left got=%h exp=7", left); end
    vectors++; if (right !== 32'd3 || rd !== 5'd4) begin miscompares++; $display("FAIL b2b_right_rd got=%h/%0d exp=3/4", right, rd); end
    $display("test_back_to_back: op=%b left=%h right=%h rd=%0d", opcode, left, right, rd);
  endtask

  task automatic test_stall();
    alu_result = 32'd4;
    out_ready = 1'b0;
    drive(1'b1, 3'b111, 5'd1, 32'd1, 5'd2, 32'd2, 1'b0, 32'd0, 5'd6);
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d] got=%0b exp=0", c, in_ready); end
      tick();
      vectors++;
      if (out_valid !== 1'b1 || opcode !== 3'b100 || left !== 32'd7 || right !== 32'd3 || rd !== 5'd4) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got=%0b/%b/%h/%h/%0d exp=1/100/7/3/4", c, out_valid, opcode, left, right, rd);
      end
      $display("test_stall: cycle %0d held op=%b left=%h", c, opcode, left);
    end
    out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got=%0b exp=1", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || opcode !== 3'b111 || left !== 32'd1 || right !== 32'd2 || rd !== 5'd6) begin
      miscompares++;
      $display("FAIL stall_release got=%0b/%b/%h/%h/%0d exp=1/111/1/2/6", out_valid, opcode, left, right, rd);
    end
    $display("test_stall: released op=%b left=%h right=%h rd=%0d", opcode, left, right, rd);
  endtask

  task automatic test_imm();
    // rs2 names the held rd, but the immediate must win
    alu_result = 32'd0;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hC;
    drive(1'b1, 3'b111, 5'd5, 32'h55, 5'd6, 32'h66, 1'b1, 32'hA, 5'd7);
    tick();
    wb_valid = 1'b0;
    vectors++; if (left !== 32'hC) begin miscompares++; $display("FAIL imm_left got=%h exp=c", left); end
    vectors++; if (right !== 32'hA) begin miscompares++; $display("FAIL imm_right got=%h exp=a", right); end
    vectors++; if (opcode !== 3'b111 || rd !== 5'd7) begin miscompares++; $display("FAIL imm_op_rd got=%b/%0d exp=111/7", opcode, rd); end
    $display("test_imm: left=%h right=%h", left, right);
  endtask

  task automatic test_x0_and_flush();
    alu_result = 32'h8;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
    drive(1'b1, 3'b000, 5'd0, 32'h33, 5'd7, 32'h77, 1'b0, 32'd0, 5'd1);
    tick();
    wb_valid = 1'b0;
    vectors++; if (left !== 32'd0) begin miscompares++; $display("FAIL x0_left got=%h exp=0", left); end
    vectors++; if (right !== 32'h8) begin miscompares++; $display("FAIL ex_fwd_rs2 got=%h exp=8", right); end
    $display("test_x0: left=%h right=%h", left, right);
    out_ready = 1'b0; flush = 1'b1;
    drive(1'b1, 3'b100, 5'd2, 32'h22, 5'd3, 32'h33, 1'b0, 32'd0, 5'd9);
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_held got=%0b exp=0", out_valid); end
    out_ready = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_incoming got=%0b exp=0", out_valid); end
    flush = 1'b0;
    $display("test_flush: out_valid=%0b", out_valid);
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    drive(1'b1, 3'b100, 5'd2, 32'h20, 5'd3, 32'h30, 1'b0, 32'd0, 5'd8);
    tick();
    vectors++; if (out_valid !== 1'b1 || left !== 32'h20) begin miscompares++; $display("FAIL pre_reset_load got=%0b/%h exp=1/20", out_valid, left); end
    reset = 1'b1; flush = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || left !== 32'd0 || right !== 32'd0 || rd !== 5'd0) begin
      miscompares++; $display("FAIL reset_mid_stall got=%0b/%h/%h/%0d exp=0/0/0/0", out_valid, left, right, rd);
    end
    $display("test_reset_mid_stall: out_valid=%0b left=%h", out_valid, left);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_imm();
    test_x0_and_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
